// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO queue, LSB-first
// serialisation at a fixed baud rate derived from the system clock.
module uart_tx #(
  parameter int unsigned CLK_HZ    = 25000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oTx,
  output logic       oBusy
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]        DIV_M1 = CW'(DIV - 1);
  localparam logic [FIFO_LOG2:0]   FULL   = (FIFO_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic [1:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic                 push;
  logic                 pop;
  logic                 baud_done;

  assign oReady    = (count != FULL);
  assign push      = iValid && oReady;
  assign baud_done = (baud_cnt == '0);
  // The head is taken either from idle or on the final stop cycle, so
  // consecutive frames follow each other with no idle gap.
  assign pop       = (count != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && baud_done));
  assign oBusy     = (count != '0) || (state != S_IDLE);

  always_ff @(posedge iClk) begin
    if (push && !iReset) begin
      mem[wr_ptr] <= iData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      oTx      <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Line level follows the state one cycle later.
      case (state)
        S_START: oTx <= 1'b0;
        S_DATA:  oTx <= shift[0];
        default: oTx <= 1'b1;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= DIV_M1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= DIV_M1;
            bit_idx  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= DIV_M1;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          if (baud_done) begin
            if (pop) begin
              shift    <= mem[rd_ptr];
              baud_cnt <= DIV_M1;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one default-rate instance (DIV=217) and one
// slow instance (DIV=10), checked with immediate assertions.
module tb_uart_tx;

  localparam int DIVB = 217;
  localparam int DIVS = 10;

  logic       clk = 1'b0;
  logic       rst_b, valid_b, ready_b, tx_b, busy_b;
  logic       rst_s, valid_s, ready_s, tx_s, busy_s;
  logic [7:0] data_b, data_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx u_big (
    .iClk(clk), .iReset(rst_b), .iData(data_b), .iValid(valid_b),
    .oReady(ready_b), .oTx(tx_b), .oBusy(busy_b)
  );

  uart_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_LOG2(4)) u_small (
    .iClk(clk), .iReset(rst_s), .iData(data_s), .iValid(valid_s),
    .oReady(ready_s), .oTx(tx_s), .oBusy(busy_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one byte into an idle, empty transmitter and check the start-bit latency.
  task automatic push_lat(input bit sel, input logic [7:0] b, input string tag);
    if (sel) begin valid_s = 1'b1; data_s = b; end
    else     begin valid_b = 1'b1; data_b = b; end
    step();                                   // edge N: push accepted
    valid_s = 1'b0;
    valid_b = 1'b0;
    chk({tag, "_busy_after_push"}, sel ? busy_s : busy_b, 1);
    chk({tag, "_tx_n"}, sel ? tx_s : tx_b, 1);
    step();                                   // edge N+1: pop into START
    chk({tag, "_tx_n1"}, sel ? tx_s : tx_b, 1);
    step();                                   // edge N+2: start bit on line
    chk({tag, "_tx_n2"}, sel ? tx_s : tx_b, 0);
  endtask

  // Called on the first cycle of the start bit; walks the full 10*div frame.
  task automatic frame_check(input bit sel, input int div, input logic [7:0] b, input string tag);
    int   bad = 0;
    logic lvl, exp, busy_late;
    int   bt;
    busy_late = 1'b0;
    for (int i = 0; i < 10 * div; i++) begin
      lvl = sel ? tx_s : tx_b;
      bt  = i / div;
      if (bt == 0)      exp = 1'b0;
      else if (bt == 9) exp = 1'b1;
      else              exp = b[bt-1];
      if (lvl !== exp) bad++;
      if (i % div == div / 2) chk($sformatf("%s_bit%0d", tag, bt), lvl, exp);
      if (i == 10 * div - 2) busy_late = sel ? busy_s : busy_b;
      step();
    end
    chk({tag, "_bad_cycles"}, bad, 0);
    chk({tag, "_busy_in_stop"}, busy_late, 1);
    chk({tag, "_busy_end"}, sel ? busy_s : busy_b, 0);
    chk({tag, "_tx_end"}, sel ? tx_s : tx_b, 1);
  endtask

  initial begin
    int         nxt, c, k, pos, bt, fe, frames, lows;
    bit         started, ready_fell;
    logic       rdy;
    logic [7:0] dec;

    rst_b = 1'b1; valid_b = 1'b0; data_b = '0;
    rst_s = 1'b1; valid_s = 1'b0; data_s = '0;
    repeat (3) step();
    chk("rst_tx", tx_b, 1);
    chk("rst_busy", busy_b, 0);
    chk("rst_ready", ready_b, 1);
    chk("rst_tx_small", tx_s, 1);
    rst_b = 1'b0;
    rst_s = 1'b0;
    step();

    // Single 0x55 at DIV=217.
    push_lat(1'b0, 8'h55, "b55");
    frame_check(1'b0, DIVB, 8'h55, "b55");

    // Single 0xA5 at DIV=10.
    push_lat(1'b1, 8'hA5, "sA5");
    frame_check(1'b1, DIVS, 8'hA5, "sA5");

    // Burst 0x00..0x13 with iValid held; decode frames assuming zero gap.
    rst_b = 1'b1; step(); rst_b = 1'b0;
    valid_b = 1'b1; data_b = 8'h00;
    nxt = 0; c = 0; fe = 0; frames = 0; dec = '0;
    started = 1'b0; ready_fell = 1'b0;
    for (int cy = 0; cy < 60000 && frames < 20; cy++) begin
      rdy = ready_b;
      if (!started && tx_b == 1'b0) started = 1'b1;
      if (started) begin
        k   = c / (10 * DIVB);
        pos = c % (10 * DIVB);
        bt  = pos / DIVB;
        if (pos % DIVB == DIVB / 2) begin
          if (bt == 0) begin
            if (tx_b !== 1'b0) fe++;
          end else if (bt <= 8) begin
            dec[bt-1] = tx_b;
          end else begin
            if (tx_b !== 1'b1) fe++;
            chk($sformatf("burst_byte%0d", k), dec, k);
            frames++;
          end
        end
        if (pos == 5 * DIVB && (k == 1 || k == 2)) chk("burst_full_ready", ready_b, 0);
        c++;
      end
      step();
      if (rdy && valid_b) begin
        nxt++;
        if (nxt >= 20) valid_b = 1'b0;
        else           data_b = 8'(nxt);
      end
      if (!ready_fell && !ready_b) begin
        ready_fell = 1'b1;
        chk("burst_accepted", nxt, 17);
      end
    end
    chk("burst_ready_fell", ready_fell, 1);
    chk("burst_frames", frames, 20);
    chk("burst_framing", fe, 0);
    chk("burst_pushed", nxt, 20);
    for (int i = 0; i < 2 * DIVB && busy_b; i++) step();
    chk("burst_busy_end", busy_b, 0);
    chk("burst_tx_end", tx_b, 1);

    // Reset in DATA with 3 bytes queued; a push alongside reset is dropped.
    rst_b = 1'b1; step(); rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_b = 1'b1;
      data_b  = 8'(8'h11 * (i + 1));
      step();
    end
    valid_b = 1'b0;
    repeat (3 * DIVB) step();
    rst_b = 1'b1; valid_b = 1'b1; data_b = 8'h99;
    step();
    rst_b = 1'b0; valid_b = 1'b0;
    chk("mid_rst_tx", tx_b, 1);
    chk("mid_rst_busy", busy_b, 0);
    chk("mid_rst_ready", ready_b, 1);
    lows = 0;
    for (int i = 0; i < 30 * DIVB; i++) begin
      if (tx_b !== 1'b1) lows++;
      step();
    end
    chk("mid_rst_no_frames", lows, 0);
    chk("mid_rst_busy_later", busy_b, 0);
    push_lat(1'b0, 8'h3C, "b3C");
    frame_check(1'b0, DIVB, 8'h3C, "b3C");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
